// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, ALU function codes and branch conditions.
// Imported by the execute stage and by anything that evaluates conditions.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] ALUADD  = 4'h0;
    localparam logic [3:0] ALUSUB  = 4'h1;
    localparam logic [3:0] ALUAND  = 4'h2;
    localparam logic [3:0] ALUXOR  = 4'h3;

    localparam logic [3:0] C_YES   = 4'h0;
    localparam logic [3:0] C_LE    = 4'h1;
    localparam logic [3:0] C_L     = 4'h2;
    localparam logic [3:0] C_E     = 4'h3;
    localparam logic [3:0] C_NE    = 4'h4;
    localparam logic [3:0] C_GE    = 4'h5;
    localparam logic [3:0] C_G     = 4'h6;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

    // cmovXX and jXX are the only instructions whose outcome depends on flags.
    function automatic logic uses_cond(input logic [3:0] icode);
        return (icode == ICMOVXX) || (icode == IJXX);
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Pure combinational Y86 condition evaluator (ifun + flags -> taken/move).
// Also instantiated by the decode-stage mispredict logic.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    output logic       c
);

    logic lt;

    always_comb begin
        lt = sf ^ of;
        c  = 1'b0;
        case (ifun)
            C_YES:   c = 1'b1;
            C_LE:    c = lt | zf;
            C_L:     c = lt;
            C_E:     c = zf;
            C_NE:    c = ~zf;
            C_GE:    c = ~lt;
            C_G:     c = ~lt & ~zf;
            default: c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_cc_execute.sv
// Execute-stage ALU with Y86 condition codes and a one-cycle registered result.
// The condition is always evaluated from the CC contents before this edge's update.
module alu_cc_execute
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic                stall,
    input  logic                cc_inhibit,
    input  logic [3:0]          icode,
    input  logic [3:0]          ifun,
    input  logic signed [W-1:0] alu_A,
    input  logic signed [W-1:0] alu_B,
    input  logic [3:0]          alu_fun,
    input  logic                set_cc,
    output logic                valid_out,
    output logic signed [W-1:0] valE,
    output logic                cnd,
    output logic                zf,
    output logic                sf,
    output logic                of
);

    logic [W-1:0] r;
    cc_t          cc_next;
    cc_t          cc_q, cc_d;
    logic         cc_we;
    logic         c_raw;
    logic         c;

    logic         valid_q, valid_d;
    logic [W-1:0] vale_q, vale_d;
    logic         cnd_q, cnd_d;

    always_comb begin
        r          = alu_B + alu_A;
        cc_next.of = 1'b0;
        case (alu_fun)
            ALUSUB: begin
                r          = alu_B - alu_A;
                cc_next.of = (alu_A[W-1] != alu_B[W-1]) && (r[W-1] != alu_B[W-1]);
            end
            ALUAND: r = alu_B & alu_A;
            ALUXOR: r = alu_B ^ alu_A;
            default: begin
                r          = alu_B + alu_A;
                cc_next.of = (alu_A[W-1] == alu_B[W-1]) && (r[W-1] != alu_A[W-1]);
            end
        endcase
        cc_next.zf = (r == '0);
        cc_next.sf = r[W-1];
    end

    cond_eval u_cond_eval (
        .ifun (ifun),
        .zf   (cc_q.zf),
        .sf   (cc_q.sf),
        .of   (cc_q.of),
        .c    (c_raw)
    );

    assign c     = uses_cond(icode) ? c_raw : 1'b1;
    assign cc_we = valid_in & set_cc & ~cc_inhibit & ~stall;

    always_comb begin
        cc_d    = cc_we ? cc_next : cc_q;
        valid_d = valid_q;
        vale_d  = vale_q;
        cnd_d   = cnd_q;
        if (!stall) begin
            valid_d = valid_in;
            // A bubble clears the payload so downstream never sees stale data.
            vale_d  = valid_in ? r : '0;
            cnd_d   = valid_in ? c : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cc_q    <= CC_RESET;
            valid_q <= 1'b0;
            vale_q  <= '0;
            cnd_q   <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            valid_q <= valid_d;
            vale_q  <= vale_d;
            cnd_q   <= cnd_d;
        end
    end

    assign valid_out = valid_q;
    assign valE      = vale_q;
    assign cnd       = cnd_q;
    assign zf        = cc_q.zf;
    assign sf        = cc_q.sf;
    assign of        = cc_q.of;

endmodule

// File: doc/alu_cc_execute.md
# alu_cc_execute

Consumer end of the execute-stage ALU operand interface. It takes the selected operands (`alu_A`, `alu_B`), the function code (`alu_fun`) and the flag-update strobe (`set_cc`). It computes `valE`, maintains the Y86 condition-code register (ZF/SF/OF) and evaluates the branch/conditional-move condition `cnd`. Results are registered with one-cycle latency toward the memory stage, under a valid/stall handshake.

## Interface
- `W`, default 64: datapath width.
- `clk`  in  1: single clock, all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. Sampled on the rising edge of `clk`; overrides every other input.
- `valid_in`  in  1: operands and controls below are meaningful this cycle.
- `stall`  in  1: hold all registered state and outputs this cycle.
- `cc_inhibit`  in  1: suppress the CC update this cycle (a later stage holds an exception).
- `icode`, `ifun`  in  4 each: instruction code and function of the instruction in execute.
- `alu_A`, `alu_B`  in  W, signed: ALU operands.
- `alu_fun`  in  4: 0 add, 1 sub, 2 and, 3 xor.
- `set_cc`  in  1: request a CC update from this result.
- `valid_out`  out  1: registered outputs hold a valid result.
- `valE`  out  W, signed: registered ALU result.
- `cnd`  out  1: registered condition outcome.
- `zf`, `sf`, `of`  out  1 each: current CC register contents.

## Operation
- **Combinational result `r`**
  - fun 0: `r = alu_B + alu_A`.
  - fun 1: `r = alu_B - alu_A`.
  - fun 2: `r = alu_B & alu_A`.
  - fun 3: `r = alu_B ^ alu_A`.
  - fun 4–15: treated as add.
  - All arithmetic wraps modulo 2^W; there is no carry output.
- **Next flags**
  - ZF = (r == 0); SF = r[W-1].
  - OF for add: operand signs are equal and the sign of `r` differs from `alu_A`.
  - OF for sub: operand signs differ and the sign of `r` differs from `alu_B`.
  - OF for and/xor: 0.
- **CC update**
  - The CC register loads the next flags when `valid_in & set_cc & ~cc_inhibit & ~stall`.
  - Otherwise it holds.
- **Condition `c`**
  - `c` uses the CC register contents before this edge's update. The same-cycle update is never used.
  - It is evaluated only for icode 2 (cmovXX) and icode 7 (jXX); for any other icode, c = 1.
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF) | ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~(SF^OF) & ~ZF.
  - ifun 7–15: 0.
- **Output register**
  - On an edge with `~stall`: `valid_out <= valid_in`.
  - If `valid_in`: `valE <= r` and `cnd <= c`.
  - Else (bubble): `valE <= 0` and `cnd <= 0`; the CC register is untouched even if `set_cc` = 1.

## Timing
- **Reset values:** `valid_out` = 0, `valE` = 0, `cnd` = 0, `zf` = 1, `sf` = 0, `of` = 0.
- **Reset mid-operation:** reset overrides `stall` and discards any pending result.
- **Latency:** 1 cycle. Inputs sampled at edge N appear on `valE`/`cnd`/`valid_out` after edge N.
- **Flag visibility:** the CC value after edge N is visible on `zf`/`sf`/`of` and used for `cnd` of the instruction sampled at edge N+1. A back-to-back OPq then jXX therefore sees the fresh flags.
- **Stall:** everything holds, including CC, regardless of `valid_in` or `set_cc`.
- **Simultaneous `set_cc` and `cc_inhibit`:** inhibit wins; `valE` is still registered.
- **State machine:** the block is two register groups (CC, output stage). The only states are reset and running.

## Structure
- **Shared package** (`y86_pkg`):
  - icode constants (`IOPQ` = 6, `IJXX` = 7, `ICMOVXX` = 2, …).
  - ALU function constants (`ALUADD`, `ALUSUB`, `ALUAND`, `ALUXOR`).
  - Condition constants (`C_YES`, `C_LE`, `C_L`, `C_E`, `C_NE`, `C_GE`, `C_G`).
- **Sub-module:** one combinational `cond_eval` (ifun, zf, sf, of → c). It is reused by the decode-stage mispredict logic.

## Test plan
- **Reset then add:** reset 1 cycle; then valid add A = 3, B = 5, set_cc = 1 → next cycle `valE` = 8, `valid_out` = 1, CC = (0,0,0). Immediately after reset, CC = (1,0,0).
- **Sub to zero:** sub A = 7, B = 7, set_cc = 1 → `valE` = 0, ZF = 1. A following jXX ifun 3 gives `cnd` = 1; ifun 4 gives `cnd` = 0.
- **Overflow:** add A = B = 0x7FFF_FFFF_FFFF_FFFF → `valE` = 0xFFFF_FFFF_FFFF_FFFE, SF = 1, OF = 1. A following jXX ifun 2 (l) gives `cnd` = 0; ifun 5 (ge) gives `cnd` = 1.
- **Stall:** stall = 1 for 2 cycles with a valid sub and set_cc = 1 → outputs and CC unchanged. On release, the result is registered and CC is updated once.
- **Bubble and inhibit:**
  - valid_in = 0 with set_cc = 1 → `valid_out` = 0, `valE` = 0, CC unchanged.
  - valid add with cc_inhibit = 1 → `valE` registered, CC unchanged.
- **Logic ops and cmov:**
  - and 0xF0 & 0x3C → 0x30, OF = 0.
  - xor 0xFF ^ 0xFF → 0, ZF = 1.
  - cmovXX ifun 0 → `cnd` = 1; ifun 9 → `cnd` = 0.
